// File: rtl/axi_pkg.sv
// Shared AXI definitions: arbiter state encoding and burst-type constants used by the
// write/read channel engines and their arbiters.
package axi_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StStart = 2'd1,
    StBusy  = 2'd2,
    StDone  = 2'd3
  } arb_state_e;

  localparam logic [1:0] BurstFixed = 2'd0;
  localparam logic [1:0] BurstIncr  = 2'd1;
  localparam logic [1:0] BurstWrap  = 2'd2;

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational rotating-priority encoder: first asserted request scanning from rr_ptr
// upward, wrapping at NUM_REQ-1.
module rr_priority_picker #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic               valid,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   idx
);

  always_comb begin
    int unsigned     pos;
    logic [IDX_W-1:0] k;
    valid = 1'b0;
    grant = '0;
    idx   = '0;
    pos   = 0;
    k     = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      pos = 32'(rr_ptr) + i;
      if (pos >= NUM_REQ) pos = pos - NUM_REQ;
      k = IDX_W'(pos);
      if (!valid && req[k]) begin
        valid    = 1'b1;
        grant[k] = 1'b1;
        idx      = k;
      end
    end
  end

endmodule

// File: rtl/axi_write_arbiter.sv
// Round-robin arbiter sharing one AXI write-channel engine among NUM_REQ requesters;
// one transfer in flight, with source-FIFO steering to the current owner.
module axi_write_arbiter
  import axi_pkg::*;
#(
  parameter int unsigned NUM_REQ             = 4,
  parameter int unsigned ADDR_WIDTH          = 32,
  parameter int unsigned WRITE_CHANNEL_WIDTH = 32,
  parameter int unsigned WRITE_BURST_LEN     = 8,
  parameter int unsigned IDX_W               = $clog2(NUM_REQ)
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [NUM_REQ-1:0]                     req,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]          req_addr,
  input  logic [NUM_REQ*WRITE_BURST_LEN-1:0]     req_len,
  input  logic [NUM_REQ*WRITE_CHANNEL_WIDTH-1:0] req_fifo_rdata,
  input  logic [NUM_REQ-1:0]                     req_fifo_rempty,
  output logic [NUM_REQ-1:0]                     req_fifo_rpull,
  output logic [NUM_REQ-1:0]                     req_grant,
  output logic [NUM_REQ-1:0]                     req_done,
  output logic                                   busy,
  output logic                                   eng_start,
  output logic [ADDR_WIDTH-1:0]                  eng_addr,
  output logic [WRITE_BURST_LEN-1:0]             eng_len,
  output logic [WRITE_CHANNEL_WIDTH-1:0]         eng_fifo_rdata,
  output logic                                   eng_fifo_rempty,
  input  logic                                   eng_fifo_rpull,
  input  logic                                   eng_done
);

  arb_state_e                 state_q, state_d;
  logic [IDX_W-1:0]           rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]           grant_idx_q, grant_idx_d;
  logic [NUM_REQ-1:0]         grant_q, grant_d;
  logic [ADDR_WIDTH-1:0]      addr_q, addr_d;
  logic [WRITE_BURST_LEN-1:0] len_q, len_d;

  logic                       pick_valid;
  logic [NUM_REQ-1:0]         pick_grant;
  logic [IDX_W-1:0]           pick_idx;

  logic [ADDR_WIDTH-1:0]          addr_arr  [NUM_REQ];
  logic [WRITE_BURST_LEN-1:0]     len_arr   [NUM_REQ];
  logic [WRITE_CHANNEL_WIDTH-1:0] rdata_arr [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign addr_arr[i]  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
    assign len_arr[i]   = req_len[i*WRITE_BURST_LEN +: WRITE_BURST_LEN];
    assign rdata_arr[i] = req_fifo_rdata[i*WRITE_CHANNEL_WIDTH +: WRITE_CHANNEL_WIDTH];
  end

  rr_priority_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_picker (
    .req    (req),
    .rr_ptr (rr_ptr_q),
    .valid  (pick_valid),
    .grant  (pick_grant),
    .idx    (pick_idx)
  );

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    grant_idx_d = grant_idx_q;
    grant_d     = grant_q;
    addr_d      = addr_q;
    len_d       = len_q;
    unique case (state_q)
      StIdle: begin
        if (pick_valid) begin
          grant_idx_d = pick_idx;
          grant_d     = pick_grant;
          addr_d      = addr_arr[pick_idx];
          len_d       = len_arr[pick_idx];
          state_d     = StStart;
        end
      end
      StStart: state_d = StBusy;
      StBusy: begin
        if (eng_done) begin
          rr_ptr_d = (grant_idx_q == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx_q + 1'b1;
          state_d  = StDone;
        end
      end
      StDone: begin
        grant_d = '0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      rr_ptr_q    <= '0;
      grant_idx_q <= '0;
      grant_q     <= '0;
      addr_q      <= '0;
      len_q       <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_idx_q <= grant_idx_d;
      grant_q     <= grant_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
    end
  end

  // FIFO path only belongs to the owner while the engine may be pulling data.
  always_comb begin
    req_done        = '0;
    req_fifo_rpull  = '0;
    eng_fifo_rdata  = '0;
    eng_fifo_rempty = 1'b1;
    if (state_q == StDone) req_done[grant_idx_q] = 1'b1;
    if (state_q == StStart || state_q == StBusy) begin
      eng_fifo_rdata              = rdata_arr[grant_idx_q];
      eng_fifo_rempty             = req_fifo_rempty[grant_idx_q];
      req_fifo_rpull[grant_idx_q] = eng_fifo_rpull;
    end
  end

  assign req_grant = grant_q;
  assign busy      = (state_q != StIdle);
  assign eng_start = (state_q == StStart);
  assign eng_addr  = addr_q;
  assign eng_len   = len_q;

endmodule
